// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - synchronised edge tick, period measurement and loss-of-signal timeout
module clock_period_meter #(
  parameter int COUNT_WIDTH    = 20,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int EDGE_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sig_in,
  output logic                   tick,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   period_valid,
  output logic                   locked,
  output logic                   timeout,
  output logic [EDGE_WIDTH-1:0]  edge_count
);

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO    = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);
  localparam logic [EDGE_WIDTH-1:0]  EDGE_ONE    = EDGE_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_TIMEOUT
  } state_t;

  state_t state_q, state_d;

  logic                   s1_q, s1_d;
  logic                   s2_q, s2_d;
  logic                   s3_q, s3_d;
  logic                   tick_q, tick_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;
  logic [EDGE_WIDTH-1:0]  edge_count_q, edge_count_d;

  logic edge_det;

  // s2 is the first metastability-safe copy; s3 remembers its previous value
  assign edge_det = s2_q & ~s3_q;

  // Synchroniser chain, tick pulse and free-running edge counter
  always_comb begin
    s1_d         = sig_in;
    s2_d         = s1_q;
    s3_d         = s2_q;
    tick_d       = edge_det;
    edge_count_d = edge_count_q;
    if (edge_det) begin
      edge_count_d = edge_count_q + EDGE_ONE;
    end
  end

  // Next state and measurement registers; an edge always outranks the timeout check
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_d      = timeout_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (edge_det) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_MEASURE: begin
        if (edge_det) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          locked_d       = 1'b1;
          cnt_d          = CNT_ONE;
        end else if (cnt_q == TIMEOUT_VAL) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          cnt_d     = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_TIMEOUT: begin
        cnt_d = CNT_ZERO;
        if (edge_det) begin
          // First edge after loss only restarts the measurement
          state_d   = ST_MEASURE;
          cnt_d     = CNT_ONE;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      tick_q         <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
      edge_count_q   <= '0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      tick_q         <= tick_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
      edge_count_q   <= edge_count_d;
    end
  end

  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;
  assign edge_count   = edge_count_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - randomized check of clock_period_meter against an edge-event model
module tb_clock_period_meter;

  localparam int CW = 8;
  localparam int TO = 20;
  localparam int EW = 4;

  logic          clock;
  logic          reset;
  logic          sig_in;
  logic          tick;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          timeout;
  logic [EW-1:0] edge_count;

  clock_period_meter #(
    .COUNT_WIDTH   (CW),
    .TIMEOUT_CYCLES(TO),
    .EDGE_WIDTH    (EW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sig_in      (sig_in),
    .tick        (tick),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout),
    .edge_count  (edge_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total;
  int bad;
  int cyc;
  int events[$];

  // Model state: expected outputs derived from the times at which edges are detected
  int m_tick, m_pv, m_period, m_locked, m_timeout, m_ecount;
  int m_active;
  int m_last;
  int pv_seen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    check_val("tick", 32'(tick), m_tick);
    check_val("period_valid", 32'(period_valid), m_pv);
    check_val("period", 32'(period), m_period);
    check_val("locked", 32'(locked), m_locked);
    check_val("timeout", 32'(timeout), m_timeout);
    check_val("edge_count", 32'(edge_count), m_ecount);
  endtask

  task automatic model_clear();
    m_tick = 0; m_pv = 0; m_period = 0; m_locked = 0; m_timeout = 0; m_ecount = 0;
    m_active = 0; m_last = 0;
    events.delete();
  endtask

  // An input edge sampled at clock edge k becomes visible at edge k+2; the gap between
  // two such events is the period, and a gap reaching TO without an event is a loss.
  task automatic model_edge();
    bit ev;
    ev = (events.size() > 0) && (events[0] == cyc);
    if (ev) void'(events.pop_front());
    m_tick = 0;
    m_pv   = 0;
    if (ev) begin
      m_tick   = 1;
      m_ecount = (m_ecount + 1) % (1 << EW);
      if (m_active != 0) begin
        m_period = cyc - m_last;
        m_pv     = 1;
        m_locked = 1;
        pv_seen++;
      end
      m_active  = 1;
      m_timeout = 0;
      m_last    = cyc;
    end else if (m_active != 0 && (cyc - m_last) == TO) begin
      m_timeout = 1;
      m_locked  = 0;
      m_active  = 0;
    end
  endtask

  task automatic step(input logic v);
    @(posedge clock);
    cyc++;
    model_edge();
    @(negedge clock);
    compare_all();
    if (v && !sig_in) events.push_back(cyc + 3);
    sig_in = v;
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) step(1'b1);
      for (int i = 0; i < lo; i++) step(1'b0);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    #1;
    compare_all();
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      compare_all();
      sig_in = 1'($urandom_range(0, 1));
    end
    sig_in = 1'b0;
    reset  = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; pv_seen = 0;
    reset = 1'b1;
    sig_in = 1'b0;
    model_clear();

    // Reset with input toggling, then quiet release
    do_reset(6);
    for (int i = 0; i < 10; i++) step(1'b0);

    // Steady period 8 across the edge_count wrap
    wave(4, 4, 18);
    check_val("steady_locked", 32'(locked), 1);
    check_val("steady_period", 32'(period), 8);

    // Loss of signal, recovery, then a new period
    for (int i = 0; i < 30; i++) step(1'b0);
    check_val("to_flag", 32'(timeout), 1);
    check_val("to_period_held", 32'(period), 8);
    wave(3, 3, 4);

    // Boundary: gap exactly TO, then TO+1
    pv_seen = 0;
    wave(10, 10, 4);
    check_val("gap20_pv_seen", pv_seen, 4);
    wave(10, 11, 4);
    pv_seen = 0;
    wave(10, 11, 4);
    check_val("gap21_no_pv", pv_seen, 0);

    // Reset mid-measure while locked
    wave(2, 5, 4);
    step(1'b0);
    do_reset(1);
    wave(3, 4, 3);

    // Randomized waveforms with occasional dropouts
    for (int k = 0; k < 40; k++) begin
      wave($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 4));
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < $urandom_range(10, 30); i++) step(1'b0);
      end
    end
    for (int i = 0; i < 30; i++) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
